if_skid_slice: RTL
==================

// Module: if_skid_slice
//
// PURPOSE
// - Registered two-entry skid stage that consumes the two-member bidirectional
//   interface bundle driven by the Inner2/Inner1 producer chain and re-drives
//   it downstream.
// - Forward members: n1 = valid, n2 = payload.
// - Reverse members: r1 = ready, r2 = flush.
// - Breaks every forward and reverse combinational path between producer and
//   consumer, while keeping full throughput and strict FIFO order.
//
// PARAMETERS
// - DATA_WIDTH  8  width of the n2 payload member.
// - CNT_WIDTH   16 width of the delivered-beat counter; wraps modulo 2**CNT_WIDTH.
//
// PORTS
// - clk        in   1           single clock; all state updates on the rising edge.
// - rst        in   1           asynchronous, active-low reset.
// - in_n1      in   1           upstream valid.
// - in_n2      in   DATA_WIDTH  upstream payload.
// - in_r1      out  1           ready to upstream; registered.
// - in_r2      out  1           flush echo to upstream; registered.
// - out_n1     out  1           downstream valid; registered.
// - out_n2     out  DATA_WIDTH  downstream payload (head entry); registered.
// - out_r1     in   1           downstream ready.
// - out_r2     in   1           downstream flush request.
// - xfer_cnt   out  CNT_WIDTH   count of beats delivered downstream.
//
// BEHAVIOUR
// - Reset (rst low, asynchronous):
//   - state = EMPTY.
//   - Both entries = 0.
//   - in_r1 = 0, in_r2 = 0, out_n1 = 0, out_n2 = 0, xfer_cnt = 0.
//   - in_r1 rises on the first clk edge after rst returns high.
// - Handshakes:
//   - push = in_n1 & in_r1.
//   - pop  = out_n1 & out_r1.
//   - Both are sampled at the rising edge.
// - States:
//   - EMPTY: out_n1 = 0, in_r1 = 1.
//   - ONE:   out_n1 = 1, in_r1 = 1.
//   - TWO:   out_n1 = 1, in_r1 = 0.
// - Transitions (no flush):
//   - EMPTY --push--> ONE.
//   - ONE --push & !pop--> TWO.
//   - ONE --pop & !push--> EMPTY.
//   - ONE --push & pop--> ONE. The new beat becomes head; zero bubble.
//   - TWO --pop--> ONE. The skid entry moves to head.
//   - Any other combination: hold state.
// - Latency: a beat pushed at edge k appears on out_n1/out_n2 after edge k when
//   the stage was EMPTY, so forward latency is 1 cycle. Sustained throughput is
//   1 beat per cycle while out_r1 stays high.
// - in_r1 is a flop output:
//   - It falls in the cycle after the ONE -> TWO transition.
//   - A push presented while in_r1 = 0 is ignored; upstream must hold it.
// - out_n2 when out_n1 = 0: holds the last head value (0 after reset); never X.
// - Flush: out_r2 sampled high at an edge has priority over push and pop.
//   - Next state = EMPTY; both entries are discarded.
//   - A concurrent push is dropped.
//   - A concurrent pop still counts, because the beat was delivered.
//   - in_r1 = 1 after the edge.
//   - in_r2 = out_r2 delayed by exactly 1 cycle.
// - xfer_cnt: +1 on every pop; wraps from 2**CNT_WIDTH-1 to 0. Flush does not
//   clear it.
// - Payload order is strict FIFO. No beat is duplicated or lost except through
//   flush.
// - Reset asserted mid-transfer: all state clears immediately. Pending entries
//   are lost; no partial beat is emitted.
//
// TESTING
// - Reset: hold rst low 3 cycles with in_n1 = 1.
//   -> out_n1 = 0, in_r1 = 0 during reset; in_r1 = 1 one edge after release.
// - Streaming: push 0x01..0x10 back-to-back with out_r1 = 1.
//   -> out_n2 = 0x01..0x10 on consecutive cycles, 1-cycle latency,
//      xfer_cnt = 16.
// - Backpressure: out_r1 = 0 and push 0xA1, 0xA2, 0xA3.
//   -> state TWO, in_r1 = 0, 0xA3 held upstream.
//   -> after out_r1 = 1, output order is 0xA1, 0xA2, 0xA3.
// - Simultaneous push & pop in ONE (head 0x55, push 0x66).
//   -> next cycle out_n2 = 0x66, out_n1 = 1, state stays ONE.
// - Flush in TWO with a concurrent push of 0x77.
//   -> next cycle out_n1 = 0, in_r1 = 1, 0x77 never appears,
//      in_r2 = 1 for exactly 1 cycle.
// - Counter wrap: CNT_WIDTH = 4, 17 pops. -> xfer_cnt = 1.

Source files
------------

// File: rtl/if_skid_slice.sv
// Two-entry registered skid stage for the valid/payload + ready/flush bundle.
// Every output is a flop, so no combinational path crosses the stage in either direction.
module if_skid_slice #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_n1,
    input  logic [DATA_WIDTH-1:0] in_n2,
    output logic                  in_r1,
    output logic                  in_r2,
    output logic                  out_n1,
    output logic [DATA_WIDTH-1:0] out_n2,
    input  logic                  out_r1,
    input  logic                  out_r2,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  in_r1_q, in_r2_q, out_n1_q;
    logic                  push, pop;

    // Handshakes use the registered ready/valid, never the combinational next state.
    assign push = in_n1 & in_r1_q;
    assign pop  = out_n1_q & out_r1;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case statement can leave it unassigned and infer a latch.
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q + CNT_WIDTH'(pop);

        if (out_r2) begin
            // Flush wins: entries become invalid, head value kept so out_n2 holds.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        head_d  = in_n2;
                    end
                end
                ONE: begin
                    unique case ({push, pop})
                        2'b10: begin
                            state_d = TWO;
                            skid_d  = in_n2;
                        end
                        2'b01:   state_d = EMPTY;
                        2'b11:   head_d  = in_n2;
                        default: state_d = ONE;
                    endcase
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            cnt_q    <= '0;
            in_r1_q  <= 1'b0;
            in_r2_q  <= 1'b0;
            out_n1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
            cnt_q    <= cnt_d;
            in_r1_q  <= (state_d != TWO);
            in_r2_q  <= out_r2;
            out_n1_q <= (state_d != EMPTY);
        end
    end

    assign in_r1    = in_r1_q;
    assign in_r2    = in_r2_q;
    assign out_n1   = out_n1_q;
    assign out_n2   = head_q;
    assign xfer_cnt = cnt_q;

endmodule
